// File: rtl/polyphase_pkg.sv
// polyphase_interp_seq shared sizing, FSM type and rounding helper.
package polyphase_pkg;

  localparam int OSF_D   = 20;
  localparam int TAPS_D  = 5;
  localparam int WIQ_D   = 16;
  localparam int WC_D    = 16;
  localparam int WO_D    = 18;
  localparam int SHIFT_D = 15;

  function automatic int buf_depth(input int osf, input int taps);
    return 2 ** $clog2(osf * taps + taps + 4);
  endfunction

  function automatic int acc_width(input int wiq, input int wc,
                                   input int taps);
    return wiq + wc + $clog2(taps);
  endfunction

  localparam int BUF_DEPTH = buf_depth(OSF_D, TAPS_D);
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int ADDR_W    = $clog2(OSF_D * TAPS_D);
  localparam int ACC_W     = acc_width(WIQ_D, WC_D, TAPS_D);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT
  } state_t;

  // {sat, value}: round-half-up, arithmetic shift, clip to wo signed bits
  function automatic logic [64:0] round_sat(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 wo
  );
    logic signed [63:0] r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    mx = (64'sd1 <<< (wo - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (wo - 1));
    if (r > mx) return {1'b1, mx};
    if (r < mn) return {1'b1, mn};
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/polyphase_coef_ram.sv
// Coefficient bank: one write port, one registered read port.
module polyphase_coef_ram #(
  parameter int DEPTH = 100,
  parameter int WC    = 16,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WC-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WC-1:0] rdata
);

  logic [WC-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < (AW + 1)'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/polyphase_interp_seq.sv
// Polyphase fractional-delay interpolator, one MAC tap per clock.
module polyphase_interp_seq
  import polyphase_pkg::*;
#(
  parameter int OSF      = OSF_D,
  parameter int TAPS_PPH = TAPS_D,
  parameter int WIQ      = WIQ_D,
  parameter int WC       = WC_D,
  parameter int WO       = WO_D,
  parameter int SHIFT    = SHIFT_D
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [WIQ-1:0]           i_raw_i,
  input  logic signed [WIQ-1:0]           q_raw_i,
  input  logic                            iq_raw_val_i,
  input  logic [$clog2(OSF)-1:0]          phase_int_i,
  input  logic                            sym_valid_i,
  input  logic                            coef_we_i,
  input  logic [$clog2(OSF*TAPS_PPH)-1:0] coef_addr_i,
  input  logic signed [WC-1:0]            coef_data_i,
  input  logic                            ovf_clr_i,
  output logic signed [WO-1:0]            i_sym_o,
  output logic signed [WO-1:0]            q_sym_o,
  output logic                            sym_valid_o,
  output logic                            busy_o,
  output logic                            ovf_o,
  output logic                            sat_o
);

  localparam int NCOEF = OSF * TAPS_PPH;
  localparam int LBUF  = buf_depth(OSF, TAPS_PPH);
  localparam int LPTR  = $clog2(LBUF);
  localparam int LADR  = $clog2(NCOEF);
  localparam int LPH   = $clog2(OSF);
  localparam int LTAP  = $clog2(TAPS_PPH + 1);
  localparam int LPRD  = WIQ + WC;
  localparam int LACC  = acc_width(WIQ, WC, TAPS_PPH);

  state_t                 state_q;
  state_t                 state_d;
  logic [LTAP-1:0]        tap_q;
  logic [LPTR-1:0]        wptr_q;
  logic [LPTR-1:0]        base_q;
  logic [LPTR-1:0]        rd_ptr;
  logic [LPH-1:0]         phase_q;
  logic [LPH-1:0]         phase_c;
  logic [LADR-1:0]        coef_rd_addr;
  logic signed [WC-1:0]   coef_q;
  logic signed [WIQ-1:0]  buf_i [LBUF];
  logic signed [WIQ-1:0]  buf_q [LBUF];
  logic signed [WIQ-1:0]  smp_i;
  logic signed [WIQ-1:0]  smp_q;
  logic signed [LPRD-1:0] prod_i;
  logic signed [LPRD-1:0] prod_q;
  logic signed [LACC-1:0] acc_i;
  logic signed [LACC-1:0] acc_q;
  logic [64:0]            rs_i;
  logic [64:0]            rs_q;
  logic                   rd_vld_q;
  logic                   accept;
  logic                   ovf_set;
  logic                   sat_set;
  logic                   last_tap;
  logic                   unused_rs;

  // busy spans the output strobe cycle so spacing is LAT+1
  assign busy_o   = (state_q != IDLE) | sym_valid_o;
  assign accept   = iq_raw_val_i & sym_valid_i & ~busy_o;
  assign ovf_set  = iq_raw_val_i & sym_valid_i & busy_o;
  assign last_tap = (tap_q == LTAP'(TAPS_PPH - 1));

  assign phase_c = ({1'b0, phase_int_i} >= (LPH + 1)'(OSF))
                 ? LPH'(OSF - 1) : phase_int_i;

  assign rd_ptr = base_q - (LPTR'(tap_q) * LPTR'(OSF)
                + LPTR'(phase_q));

  assign coef_rd_addr = LADR'(phase_q) * LADR'(TAPS_PPH)
                      + LADR'(tap_q);

  polyphase_coef_ram #(
    .DEPTH (NCOEF),
    .WC    (WC),
    .AW    (LADR)
  ) u_coef (
    .clk   (clk),
    .we    (coef_we_i & ~busy_o),
    .waddr (coef_addr_i),
    .wdata (coef_data_i),
    .raddr (coef_rd_addr),
    .rdata (coef_q)
  );

  always_ff @(posedge clk) begin
    if (iq_raw_val_i) begin
      buf_i[wptr_q] <= i_raw_i;
      buf_q[wptr_q] <= q_raw_i;
    end
    smp_i <= buf_i[rd_ptr];
    smp_q <= buf_q[rd_ptr];
  end

  assign prod_i = LPRD'(smp_i) * LPRD'(coef_q);
  assign prod_q = LPRD'(smp_q) * LPRD'(coef_q);

  assign rs_i = round_sat(64'(acc_i), SHIFT, WO);
  assign rs_q = round_sat(64'(acc_q), SHIFT, WO);
  assign sat_set   = (state_q == OUT) & (rs_i[64] | rs_q[64]);
  assign unused_rs = ^{rs_i[63:WO], rs_q[63:WO]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (last_tap) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      wptr_q      <= '0;
      base_q      <= '0;
      phase_q     <= '0;
      rd_vld_q    <= 1'b0;
      acc_i       <= '0;
      acc_q       <= '0;
      i_sym_o     <= '0;
      q_sym_o     <= '0;
      sym_valid_o <= 1'b0;
      ovf_o       <= 1'b0;
      sat_o       <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= (state_q == FETCH);
      if (iq_raw_val_i) wptr_q <= wptr_q + 1'b1;
      if (accept) begin
        base_q  <= wptr_q;
        phase_q <= phase_c;
        tap_q   <= '0;
        acc_i   <= '0;
        acc_q   <= '0;
      end else begin
        if (state_q == FETCH) tap_q <= tap_q + 1'b1;
        if (rd_vld_q) begin
          acc_i <= acc_i + LACC'(prod_i);
          acc_q <= acc_q + LACC'(prod_q);
        end
      end
      sym_valid_o <= (state_q == OUT);
      if (state_q == OUT) begin
        i_sym_o <= rs_i[WO-1:0];
        q_sym_o <= rs_q[WO-1:0];
      end
      if (ovf_set)        ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
      if (sat_set)        sat_o <= 1'b1;
      else if (ovf_clr_i) sat_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_polyphase_interp_seq.sv
// Directed bench for polyphase_interp_seq at default parameters.
module tb_polyphase_interp_seq;
  import polyphase_pkg::*;

  localparam logic signed [17:0] POS_FS = 18'h1FFFF;
  localparam logic signed [17:0] NEG_FS = 18'h20000;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic signed [15:0]       i_raw_i;
  logic signed [15:0]       q_raw_i;
  logic                     iq_raw_val_i;
  logic [4:0]               phase_int_i;
  logic                     sym_valid_i;
  logic                     coef_we_i;
  logic [ADDR_W-1:0]        coef_addr_i;
  logic signed [15:0]       coef_data_i;
  logic                     ovf_clr_i;
  logic signed [17:0]       i_sym_o;
  logic signed [17:0]       q_sym_o;
  logic                     sym_valid_o;
  logic                     busy_o;
  logic                     ovf_o;
  logic                     sat_o;

  int                 vectors = 0;
  int                 errors  = 0;
  int                 pulses;
  int                 lat;
  logic signed [17:0] got_i;
  logic signed [17:0] got_q;
  logic               busy_we;
  logic signed [17:0] snap_i;
  logic signed [17:0] snap_q;
  logic [3:0]         snap_f;

  always #5 clk = ~clk;

  polyphase_interp_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_raw_i      (i_raw_i),
    .q_raw_i      (q_raw_i),
    .iq_raw_val_i (iq_raw_val_i),
    .phase_int_i  (phase_int_i),
    .sym_valid_i  (sym_valid_i),
    .coef_we_i    (coef_we_i),
    .coef_addr_i  (coef_addr_i),
    .coef_data_i  (coef_data_i),
    .ovf_clr_i    (ovf_clr_i),
    .i_sym_o      (i_sym_o),
    .q_sym_o      (q_sym_o),
    .sym_valid_o  (sym_valid_o),
    .busy_o       (busy_o),
    .ovf_o        (ovf_o),
    .sat_o        (sat_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input logic signed [15:0] d);
    coef_we_i   = 1'b1;
    coef_addr_i = ADDR_W'(a);
    coef_data_i = d;
    tick();
    coef_we_i   = 1'b0;
  endtask

  task automatic fill_coef(input logic signed [15:0] d);
    for (int a = 0; a < OSF_D * TAPS_D; a++) wr_coef(a, d);
  endtask

  task automatic push(input logic signed [15:0] iv,
                      input logic signed [15:0] qv, input int n);
    for (int k = 0; k < n; k++) begin
      iq_raw_val_i = 1'b1;
      i_raw_i      = iv;
      q_raw_i      = qv;
      sym_valid_i  = 1'b0;
      tick();
    end
    iq_raw_val_i = 1'b0;
  endtask

  // strobe at c=0, optional second strobe, coef write, reset window
  task automatic run(input logic signed [15:0] iv,
                     input logic signed [15:0] qv,
                     input logic [4:0] ph, input int s2,
                     input int we_at, input int rst_at);
    pulses  = 0;
    lat     = 0;
    busy_we = 1'b0;
    for (int c = 0; c < 24; c++) begin
      iq_raw_val_i = 1'b1;
      i_raw_i      = iv;
      q_raw_i      = qv;
      phase_int_i  = ph;
      sym_valid_i  = (c == 0) || (c == s2);
      coef_we_i    = (c == we_at);
      coef_addr_i  = ADDR_W'(3 * TAPS_D + 2);
      coef_data_i  = 16'sd0;
      if (c == we_at) busy_we = busy_o;
      rst_n = !(rst_at >= 0 && c >= rst_at && c < rst_at + 3);
      tick();
      if (c == rst_at) begin
        snap_i = i_sym_o;
        snap_q = q_sym_o;
        snap_f = {sym_valid_o, busy_o, ovf_o, sat_o};
      end
      if (sym_valid_o) begin
        pulses++;
        if (pulses == 1) begin
          lat   = c + 1;
          got_i = i_sym_o;
          got_q = q_sym_o;
        end
      end
    end
    iq_raw_val_i = 1'b0;
    sym_valid_i  = 1'b0;
    coef_we_i    = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic flag_clear();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
  endtask

  task automatic impulse_setup(input int gap);
    push(16'sd0, 16'sd0, BUF_DEPTH);
    push(16'sd8000, 16'sd0, 1);
    push(16'sd0, 16'sd0, gap - 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_raw_i = '0; q_raw_i = '0; iq_raw_val_i = 1'b0;
    phase_int_i = '0; sym_valid_i = 1'b0; coef_we_i = 1'b0;
    coef_addr_i = '0; coef_data_i = '0; ovf_clr_i = 1'b0;
    repeat (3) tick();
    vectors++;
    if (i_sym_o !== 18'sd0) begin
      errors++; $display("FAIL rst_i got %0d want 0", i_sym_o);
    end
    vectors++;
    if (q_sym_o !== 18'sd0) begin
      errors++; $display("FAIL rst_q got %0d want 0", q_sym_o);
    end
    vectors++;
    if ({sym_valid_o, busy_o, ovf_o, sat_o} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               {sym_valid_o, busy_o, ovf_o, sat_o});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_impulse();
    fill_coef(16'sd0);
    wr_coef(3 * TAPS_D + 2, 16'sd32767);
    impulse_setup(43);
    run(16'sd0, 16'sd0, 5'd3, -1, 2, -1);
    vectors++;
    if (pulses != 1) begin
      errors++; $display("FAIL imp_pulses got %0d want 1", pulses);
    end
    vectors++;
    if (lat != 8) begin
      errors++; $display("FAIL imp_latency got %0d want 8", lat);
    end
    vectors++;
    if (got_i !== 18'sd8000) begin
      errors++; $display("FAIL imp_i got %0d want 8000", got_i);
    end
    vectors++;
    if (got_q !== 18'sd0) begin
      errors++; $display("FAIL imp_q got %0d want 0", got_q);
    end
    vectors++;
    if (busy_we !== 1'b1) begin
      errors++; $display("FAIL imp_busy_at_write got %b want 1", busy_we);
    end
  endtask

  task automatic test_coef_write_busy();
    impulse_setup(43);
    run(16'sd0, 16'sd0, 5'd3, -1, -1, -1);
    vectors++;
    if (got_i !== 18'sd8000 || lat != 8) begin
      errors++;
      $display("FAIL coef_busy_i got %0d lat %0d want 8000 lat 8",
               got_i, lat);
    end
  endtask

  task automatic test_phase_clamp();
    wr_coef(19 * TAPS_D, 16'sd32767);
    impulse_setup(19);
    run(16'sd0, 16'sd0, 5'd25, -1, -1, -1);
    vectors++;
    if (got_i !== 18'sd8000) begin
      errors++; $display("FAIL clamp_i got %0d want 8000", got_i);
    end
  endtask

  task automatic test_dc_gain();
    logic [4:0] phs [3];
    phs[0] = 5'd0; phs[1] = 5'd11; phs[2] = 5'd19;
    fill_coef(16'sd16384);
    push(16'sd1000, -16'sd1000, BUF_DEPTH);
    for (int k = 0; k < 3; k++) begin
      run(16'sd1000, -16'sd1000, phs[k], -1, -1, -1);
      vectors++;
      if (got_i !== 18'sd2500 || got_q !== -18'sd2500) begin
        errors++;
        $display("FAIL dc_ph%0d got %0d/%0d want 2500/-2500",
                 phs[k], got_i, got_q);
      end
    end
    vectors++;
    if (sat_o !== 1'b0) begin
      errors++; $display("FAIL dc_sat got %b want 0", sat_o);
    end
  endtask

  task automatic test_back_to_back();
    run(16'sd1000, -16'sd1000, 5'd0, 9, -1, -1);
    vectors++;
    if (pulses != 2 || ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_spacing9 got pulses %0d ovf %b want 2 0",
               pulses, ovf_o);
    end
  endtask

  task automatic test_overrun();
    run(16'sd1000, -16'sd1000, 5'd7, 3, -1, -1);
    vectors++;
    if (pulses != 1) begin
      errors++; $display("FAIL ovr_pulses got %0d want 1", pulses);
    end
    vectors++;
    if (got_i !== 18'sd2500 || lat != 8) begin
      errors++;
      $display("FAIL ovr_result got %0d lat %0d want 2500 lat 8",
               got_i, lat);
    end
    vectors++;
    if (ovf_o !== 1'b1) begin
      errors++; $display("FAIL ovr_flag got %b want 1", ovf_o);
    end
    flag_clear();
    vectors++;
    if (ovf_o !== 1'b0) begin
      errors++; $display("FAIL ovr_clear got %b want 0", ovf_o);
    end
    run(16'sd1000, -16'sd1000, 5'd0, 8, -1, -1);
    vectors++;
    if (pulses != 1 || ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_spacing8 got pulses %0d ovf %b want 1 1",
               pulses, ovf_o);
    end
    flag_clear();
  endtask

  task automatic test_saturation();
    fill_coef(16'sd32767);
    push(16'sd32767, -16'sd32768, BUF_DEPTH);
    run(16'sd32767, -16'sd32768, 5'd5, -1, -1, -1);
    vectors++;
    if (got_i !== POS_FS) begin
      errors++; $display("FAIL sat_i got %0d want 131071", got_i);
    end
    vectors++;
    if (got_q !== NEG_FS) begin
      errors++; $display("FAIL sat_q got %0d want -131072", got_q);
    end
    vectors++;
    if (sat_o !== 1'b1) begin
      errors++; $display("FAIL sat_flag got %b want 1", sat_o);
    end
    flag_clear();
    vectors++;
    if (sat_o !== 1'b0) begin
      errors++; $display("FAIL sat_clear got %b want 0", sat_o);
    end
  endtask

  task automatic test_reset_mid();
    run(16'sd32767, -16'sd32768, 5'd5, -1, -1, 4);
    vectors++;
    if (pulses != 0) begin
      errors++; $display("FAIL rmid_pulses got %0d want 0", pulses);
    end
    vectors++;
    if (snap_i !== 18'sd0 || snap_q !== 18'sd0) begin
      errors++;
      $display("FAIL rmid_out got %0d/%0d want 0/0", snap_i, snap_q);
    end
    vectors++;
    if (snap_f !== 4'b0000) begin
      errors++; $display("FAIL rmid_flags got %b want 0000", snap_f);
    end
    push(16'sd32767, -16'sd32768, BUF_DEPTH);
    run(16'sd32767, -16'sd32768, 5'd5, -1, -1, -1);
    vectors++;
    if (pulses != 1 || lat != 8 || got_i !== POS_FS
        || got_q !== NEG_FS) begin
      errors++;
      $display("FAIL rmid_fresh got p%0d lat%0d %0d/%0d want 1 8 131071/-131072",
               pulses, lat, got_i, got_q);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_coef_write_busy();
    test_phase_clamp();
    test_dc_gain();
    test_back_to_back();
    test_overrun();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/polyphase_interp_seq.md
# polyphase_interp_seq

Synthesizable, parametrised polyphase fractional-delay interpolator for the MSK receiver timing-recovery path. It sits between the raw I/Q sample stream and the symbol-rate demodulator. On each symbol strobe it computes one interpolated I/Q pair using a runtime-loadable coefficient bank with separate coefficients per phase and tap. A time-multiplexed MAC handles one tap per clock, with rounding, saturation and overrun/saturation flags.

## Interface
- OSF, 20: polyphase branches (samples/symbol)
- TAPS_PPH, 5: taps per branch
- WIQ, 16: input sample width
- WC, 16: coefficient width, signed Q1.(WC-1)
- WO, 18: output width
- SHIFT, 15: accumulator right-shift before rounding
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- i_raw_i / q_raw_i  in  WIQ  signed raw samples
- iq_raw_val_i  in  1  sample valid
- phase_int_i  in  $clog2(OSF)  phase branch select
- sym_valid_i  in  1  symbol strobe, qualified by iq_raw_val_i
- coef_we_i  in  1  coefficient write enable
- coef_addr_i  in  $clog2(OSF*TAPS_PPH)  coefficient address = phase*TAPS_PPH + tap
- coef_data_i  in  WC  signed coefficient
- ovf_clr_i  in  1  clears ovf_o and sat_o
- i_sym_o / q_sym_o  out  WO  signed interpolated symbol
- sym_valid_o  out  1  one-cycle output strobe
- busy_o  out  1  computation in progress
- ovf_o  out  1  sticky: strobe dropped while busy
- sat_o  out  1  sticky: output saturated

## Operation
- History buffer: circular, BUF_DEPTH = 2^clog2(OSF*TAPS_PPH + TAPS_PPH + 4), one per rail. Written on every iq_raw_val_i cycle; the write pointer wraps naturally.
- Strobe: the accepted strobe cycle is iq_raw_val_i & sym_valid_i & !busy_o. The sample written in that cycle is x[n]. The block snapshots the base pointer and phase p.
- Tap k (0..TAPS_PPH-1) computes x[n - k*OSF - p] * c[p][k]. Reads use modulo-BUF_DEPTH arithmetic. Buffer slack guarantees that in-flight writes never overwrite a needed sample.
- phase_int_i >= OSF: clamped to OSF-1.
- FSM:
  - IDLE: on accepted strobe → FETCH.
  - FETCH: TAPS_PPH cycles issuing reads → DRAIN.
  - DRAIN: 1 cycle, last product accumulates → OUT.
  - OUT: round/saturate, register outputs, pulse sym_valid_o → IDLE.
- Arithmetic:
  - Products are WIQ+WC bits.
  - Accumulator is WIQ+WC+clog2(TAPS_PPH) bits, no internal overflow.
  - Output = sat_WO((acc + 2^(SHIFT-1)) >>> SHIFT), round-half-up.
  - Any saturation on either rail sets sat_o.
- Strobe while busy_o: dropped, ovf_o set; the computation in flight is unaffected.
- Coefficient writes: ignored while busy_o=1 so that a computation never sees a mixed coefficient set. Coefficient RAM is not cleared by reset and initialises to zero at configuration.
- ovf_clr_i and a new flag event in the same cycle: the set wins.
- i_sym_o/q_sym_o hold their value between strobes.

## Timing
- Reset values: i_sym_o=0, q_sym_o=0, sym_valid_o=0, busy_o=0, ovf_o=0, sat_o=0. FSM goes to IDLE, buffer pointer 0. Buffer contents are not cleared.
- Latency: sym_valid_o is high exactly LAT = TAPS_PPH+3 cycles after the accepted strobe edge, for one cycle. This is 8 cycles at defaults.
- busy_o is high from the cycle after the strobe through the sym_valid_o cycle inclusive. The minimum accepted strobe spacing is LAT+1 cycles.
- Coefficient RAM read latency is 1 cycle. A write is visible to the next computation started after the write cycle.
- rst_n asserted mid-computation: the result is abandoned, no sym_valid_o pulse, and outputs return to reset values.

## Structure
- Package polyphase_pkg holds:
  - localparams for BUF_DEPTH and the pointer, address and accumulator widths
  - FSM state typedef (IDLE, FETCH, DRAIN, OUT)
  - function round_sat(acc, SHIFT, WO) returning {sat flag, value}
- Sub-module polyphase_coef_ram: simple dual-port, 1 write port, 1 registered read port, OSF*TAPS_PPH x WC.

## Test plan
- Impulse:
  - Stimulus: load only c[3][2]=32767; send I sample 8000 at n0, zeros elsewhere; strobe at n0+43 with phase 3.
  - Response: i_sym_o=8000, q_sym_o=0, sym_valid_o 8 cycles after the strobe.
- DC gain:
  - Stimulus: load all coefficients 16384; constant I=1000, Q=-1000.
  - Response: every strobe gives I=2500, Q=-2500, sat_o=0.
- Saturation:
  - Stimulus: all coefficients 32767; I=32767, Q=-32768.
  - Response: I=131071, Q=-131072, sat_o=1; ovf_clr_i clears it.
- Overrun:
  - Stimulus: second strobe 3 cycles after the first.
  - Response: exactly one sym_valid_o, ovf_o=1, first result correct.
- Coefficient write during busy:
  - Stimulus: write 0 to c[3][2] while busy_o=1 in the impulse test.
  - Response: that result is still 8000, and the next impulse strobe also returns 8000 (write ignored).
- Reset mid-operation:
  - Stimulus: drop rst_n 4 cycles after a strobe.
  - Response: no sym_valid_o, all outputs 0, a fresh strobe after release produces correct output.
